result_bcd_formatter: RTL and testbench



---
 rtl/result_bcd_formatter.sv | 136 +++++++++++++
 tb/tb_result_bcd_formatter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_formatter.sv
// Signed binary to sign + fixed-width ASCII decimal, using an iterative double-dabble engine.
// Build option: RESULT_FMT_LEADING_ZERO_BLANK_EN renders leading zero digits as spaces.
module result_bcd_formatter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            sign_char,
    output logic [8*DIGITS-1:0]   digits
);

    // state  | meaning
    // IDLE   | waiting for an input handshake
    // SHIFT  | WIDTH add-3/shift iterations of the magnitude into BCD
    // FORMAT | BCD nibbles converted to ASCII and loaded into the outputs
    // DONE   | result held until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Decimal digit count of 2^(WIDTH-1) is floor((WIDTH-1)*log10(2)) + 1.
    localparam longint LOG_SCALED = longint'(WIDTH - 1) * 64'sd30103;
    localparam int     MIN_DIGITS = int'(LOG_SCALED / 64'sd100000) + 1;

    if (DIGITS < MIN_DIGITS) begin : g_digits_check
        $error("result_bcd_formatter: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    function automatic logic [4*DIGITS-1:0] add3_nibbles(input logic [4*DIGITS-1:0] bcd);
        logic [4*DIGITS-1:0] res;
        logic [3:0]          nib;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd[4*i +: 4];
            res[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
        return res;
    endfunction

    function automatic logic [8*DIGITS-1:0] format_bcd(input logic [4*DIGITS-1:0] bcd);
        logic [8*DIGITS-1:0] txt;
        logic [3:0]          nib;
`ifdef RESULT_FMT_LEADING_ZERO_BLANK_EN
        logic                seen;
        seen = 1'b0;
`endif
        txt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
`ifdef RESULT_FMT_LEADING_ZERO_BLANK_EN
            // Digit 0 always shows a numeral so zero still renders as "0".
            if ((nib != 4'd0) || (i == 0)) seen = 1'b1;
            txt[8*i +: 8] = seen ? (8'h30 + {4'h0, nib}) : 8'h20;
`else
            txt[8*i +: 8] = 8'h30 + {4'h0, nib};
`endif
        end
        return txt;
    endfunction

    localparam logic [8*DIGITS-1:0] ZERO_TEXT = format_bcd('0);

    state_t                     state;
    logic                       neg_q;
    logic [WIDTH-1:0]           mag_q;
    logic [4*DIGITS-1:0]        bcd_q;
    logic [CNT_W-1:0]           iter_q;
    logic [4*DIGITS-1:0]        bcd_adj;
    logic [4*DIGITS+WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]           mag_in;

    assign in_ready = (state == IDLE);
    assign bcd_adj  = add3_nibbles(bcd_q);
    assign shifted  = {bcd_adj, mag_q} << 1;
    // The most negative value wraps back to itself, which read unsigned is 2^(WIDTH-1).
    assign mag_in   = data_in[WIDTH-1] ? ((~data_in) + WIDTH'(1)) : data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            out_valid <= 1'b0;
            sign_char <= 8'h20;
            digits    <= ZERO_TEXT;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg_q  <= data_in[WIDTH-1];
                        mag_q  <= mag_in;
                        bcd_q  <= '0;
                        iter_q <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= shifted;
                    if (iter_q == LAST_ITER) begin
                        state <= FORMAT;
                    end else begin
                        iter_q <= iter_q + CNT_W'(1);
                    end
                end
                FORMAT: begin
                    sign_char <= neg_q ? 8'h2D : 8'h20;
                    digits    <= format_bcd(bcd_q);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed self-checking bench for result_bcd_formatter (WIDTH=32, DIGITS=10).
// Honours RESULT_FMT_LEADING_ZERO_BLANK_EN for the expected digit strings.
module tb_result_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  sign_char;
    logic [79:0] digits;

    int n_checks = 0;
    int n_fail   = 0;

    result_bcd_formatter #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_char (sign_char),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers v in IDLE, returns the number of edges from accept to out_valid.
    task automatic convert(input logic [31:0] v, output int lat);
        @(negedge clk);
        chk("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        data_in  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_low_after_accept", in_ready, 1'b0);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_low_after_take", out_valid, 1'b0);
        chk("ready_high_after_take", in_ready, 1'b1);
    endtask

    initial begin
        int          lat;
        logic        seen_valid;
        logic [79:0] e_zero, e_60, e_min, e_max, e_m1, e_bp, e_m7;

`ifdef RESULT_FMT_LEADING_ZERO_BLANK_EN
        e_zero = "         0";
        e_60   = "        60";
        e_m1   = "         1";
        e_bp   = "       305";
        e_m7   = "         7";
`else
        e_zero = "0000000000";
        e_60   = "0000000060";
        e_m1   = "0000000001";
        e_bp   = "0000000305";
        e_m7   = "0000000007";
`endif
        e_min = "2147483648";
        e_max = "2147483647";

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sign", sign_char, 8'h20);
        chk("rst_digits", digits, e_zero);

        // 60 with latency
        convert(32'd60, lat);
        chk("lat_60", lat, 33);
        chk("sign_60", sign_char, 8'h20);
        chk("digits_60", digits, e_60);
        consume();

        // Extremes
        convert(32'h8000_0000, lat);
        chk("lat_min", lat, 33);
        chk("sign_min", sign_char, 8'h2D);
        chk("digits_min", digits, e_min);
        consume();
        convert(32'h7FFF_FFFF, lat);
        chk("sign_max", sign_char, 8'h20);
        chk("digits_max", digits, e_max);
        consume();

        // Zero and -1
        convert(32'd0, lat);
        chk("sign_zero", sign_char, 8'h20);
        chk("digits_zero", digits, e_zero);
        consume();
        convert(32'hFFFF_FFFF, lat);
        chk("sign_m1", sign_char, 8'h2D);
        chk("digits_m1", digits, e_m1);
        consume();

        // Backpressure with an ignored input pulse
        convert(-32'sd305, lat);
        chk("sign_bp", sign_char, 8'h2D);
        chk("digits_bp", digits, e_bp);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            data_in  = 32'd99;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_ready_low", in_ready, 1'b0);
            chk("bp_sign_held", sign_char, 8'h2D);
            chk("bp_digits_held", digits, e_bp);
        end
        consume();
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_99_ignored_valid", out_valid, 1'b0);
        chk("bp_99_ignored_ready", in_ready, 1'b1);
        chk("bp_digits_kept", digits, e_bp);

        // Reset mid-SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 32'd12345;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_digits", digits, e_zero);
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_result", seen_valid, 1'b0);
        convert(-32'sd7, lat);
        chk("lat_m7", lat, 33);
        chk("sign_m7", sign_char, 8'h2D);
        chk("digits_m7", digits, e_m7);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
